// File: rtl/hash_target_scan.sv
// Scans NUM_NONCE H0 words against a difficulty target, tracks the first hit and
// the minimum word, then writes a 3-word result record through the memory port.
module hash_target_scan #(
    parameter int NUM_NONCE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [7:0]  first_idx,
    output logic [31:0] min_hash,
    output logic [7:0]  min_idx,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(NUM_NONCE - 1);
    localparam logic [7:0] NN   = 8'(NUM_NONCE);

    state_t      state_q, state_d;
    logic [7:0]  offset_q, offset_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  first_idx_q, first_idx_d;
    logic [7:0]  min_idx_q, min_idx_d;
    logic        found_q, found_d;
    logic        done_q, done_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] target_q, target_d;
    logic [31:0] min_hash_q, min_hash_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  idx;
    logic [15:0] base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            offset_q    <= 8'd0;
            cnt_q       <= 8'd0;
            first_idx_q <= 8'd0;
            min_idx_q   <= 8'd0;
            found_q     <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            target_q    <= 32'd0;
            min_hash_q  <= 32'hFFFF_FFFF;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            cnt_q       <= cnt_d;
            first_idx_q <= first_idx_d;
            min_idx_q   <= min_idx_d;
            found_q     <= found_d;
            done_q      <= done_d;
            mem_we_q    <= mem_we_d;
            target_q    <= target_d;
            min_hash_q  <= min_hash_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (cnt_q == NN) state_d = WRITE;
            WRITE:   if (cnt_q == 8'd3) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In READ, cnt_q = k+1 on the edge that captures word k (one-cycle memory latency).
    always_comb begin
        offset_d    = offset_q;
        cnt_d       = cnt_q;
        first_idx_d = first_idx_q;
        min_idx_d   = min_idx_q;
        found_d     = found_q;
        done_d      = 1'b0;
        mem_we_d    = 1'b0;
        target_d    = target_q;
        min_hash_d  = min_hash_q;
        wdata_d     = wdata_q;
        idx         = cnt_q - 8'd1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d    = target;
                    found_d     = 1'b0;
                    first_idx_d = 8'd0;
                    min_hash_d  = 32'hFFFF_FFFF;
                    min_idx_d   = 8'd0;
                    offset_d    = 8'd0;
                    cnt_d       = 8'd0;
                end
            end
            READ: begin
                if (offset_q != LAST) offset_d = offset_q + 8'd1;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q != 8'd0) begin
                    if (mem_read_data < target_q && !found_q) begin
                        found_d     = 1'b1;
                        first_idx_d = idx;
                    end
                    if (cnt_q == 8'd1 || mem_read_data < min_hash_q) begin
                        min_hash_d = mem_read_data;
                        min_idx_d  = idx;
                    end
                end
                if (cnt_q == NN) begin
                    offset_d = 8'd0;
                    cnt_d    = 8'd0;
                end
            end
            WRITE: begin
                if (cnt_q < 8'd3) begin
                    mem_we_d = 1'b1;
                    offset_d = cnt_q;
                    cnt_d    = cnt_q + 8'd1;
                    case (cnt_q)
                        8'd0:    wdata_d = {found_q, 23'd0, first_idx_q};
                        8'd1:    wdata_d = min_hash_q;
                        default: wdata_d = {24'd0, min_idx_q};
                    endcase
                end else begin
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        base     = (state_q == WRITE) ? result_addr : hash_addr;
        mem_addr = base + {8'd0, offset_q};
    end

    assign mem_clk        = clk;
    assign mem_we         = mem_we_q;
    assign mem_write_data = wdata_q;
    assign done           = done_q;
    assign found          = found_q;
    assign first_idx      = first_idx_q;
    assign min_hash       = min_hash_q;
    assign min_idx        = min_idx_q;

endmodule

// File: tb/tb_hash_target_scan.sv
// Bench for hash_target_scan: a 16-word and a 1-word instance share one
// synchronous memory; records are checked against a reference model.
module tb_hash_target_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] hash_addr = 16'h0100;
    logic [15:0] result_addr = 16'h0200;
    logic [31:0] target = 32'd0;

    logic        done_a, found_a, mclk_a, we_a;
    logic [7:0]  fi_a, mi_a;
    logic [31:0] mh_a, wd_a, rd_a;
    logic [15:0] addr_a;
    logic        done_b, found_b, mclk_b, we_b;
    logic [7:0]  fi_b, mi_b;
    logic [31:0] mh_b, wd_b, rd_b;
    logic [15:0] addr_b;

    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = 16'd0;
    logic [31:0] ld_data = 32'd0;
    logic [31:0] mem [0:65535];
    logic [31:0] words [0:255];

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    hash_target_scan #(.NUM_NONCE(16)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .hash_addr(hash_addr), .result_addr(result_addr), .target(target),
        .done(done_a), .found(found_a), .first_idx(fi_a),
        .min_hash(mh_a), .min_idx(mi_a), .mem_clk(mclk_a),
        .mem_we(we_a), .mem_addr(addr_a), .mem_write_data(wd_a),
        .mem_read_data(rd_a)
    );

    hash_target_scan #(.NUM_NONCE(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .hash_addr(hash_addr), .result_addr(result_addr), .target(target),
        .done(done_b), .found(found_b), .first_idx(fi_b),
        .min_hash(mh_b), .min_idx(mi_b), .mem_clk(mclk_b),
        .mem_we(we_b), .mem_addr(addr_b), .mem_write_data(wd_b),
        .mem_read_data(rd_b)
    );

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (we_a) mem[addr_a] <= wd_a;
        if (we_b) mem[addr_b] <= wd_b;
        rd_a <= mem[addr_a];
        rd_b <= mem[addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Reference: first index strictly below target, and the earliest smallest word.
    task automatic model(input int n, output logic [31:0] r0, output logic [31:0] r1,
                         output logic [31:0] r2);
        logic f;
        logic [7:0] fi;
        logic [31:0] mh;
        logic [7:0] mi;
        f = 1'b0;
        fi = 8'd0;
        for (int k = n - 1; k >= 0; k--)
            if (words[k] < target) begin
                f = 1'b1;
                fi = 8'(k);
            end
        mh = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++)
            if (words[k] < mh) mh = words[k];
        mi = 8'd0;
        for (int k = n - 1; k >= 0; k--)
            if (words[k] == mh) mi = 8'(k);
        r0 = {f, 23'd0, fi};
        r1 = mh;
        r2 = {24'd0, mi};
    endtask

    task automatic run(input bit sel, input int n, input int pulse_at, input string tag);
        logic [31:0] r0, r1, r2, tsave;
        int lat;
        int wes;
        lat = 0;
        wes = 0;
        for (int k = 0; k < n; k++) wr(hash_addr + 16'(k), words[k]);
        for (int j = 0; j < 3; j++) wr(result_addr + 16'(j), 32'hDEADBEEF);
        model(n, r0, r1, r2);
        tsave = target;
        @(negedge clk);
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        start_b = 1'b0;
        target = ~tsave;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            if (i == pulse_at) start_a = 1'b1;
            @(posedge clk);
            #1 start_a = 1'b0;
            if (sel ? we_b : we_a) wes++;
            if (sel ? done_b : done_a) lat = i;
        end
        target = tsave;
        chk({tag, "/latency"}, 32'(lat), 32'(n + 5));
        chk({tag, "/we_cycles"}, 32'(wes), 32'd3);
        chk({tag, "/rec0"}, mem[result_addr], r0);
        chk({tag, "/rec1"}, mem[result_addr + 16'd1], r1);
        chk({tag, "/rec2"}, mem[result_addr + 16'd2], r2);
        chk({tag, "/found"}, {31'd0, sel ? found_b : found_a}, {31'd0, r0[31]});
        chk({tag, "/first_idx"}, {24'd0, sel ? fi_b : fi_a}, {24'd0, r0[7:0]});
        chk({tag, "/min_hash"}, sel ? mh_b : mh_a, r1);
        chk({tag, "/min_idx"}, {24'd0, sel ? mi_b : mi_a}, r2);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/we"}, {31'd0, we_a}, 32'd0);
        chk({tag, "/done"}, {31'd0, done_a}, 32'd0);
        chk({tag, "/found"}, {31'd0, found_a}, 32'd0);
        chk({tag, "/first_idx"}, {24'd0, fi_a}, 32'd0);
        chk({tag, "/min_hash"}, mh_a, 32'hFFFF_FFFF);
        chk({tag, "/min_idx"}, {24'd0, mi_a}, 32'd0);
        chk({tag, "/wdata"}, wd_a, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_reset("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 16; k++) words[k] = 32'h1000 + 32'(k);
        target = 32'h0000_1005;
        run(1'b0, 16, 0, "t1");

        for (int k = 0; k < 16; k++) words[k] = 32'hFFFF_FFF0 - 32'(k);
        target = 32'h0000_0001;
        run(1'b0, 16, 0, "t2");

        for (int k = 0; k < 16; k++) words[k] = 32'h8000_0000;
        words[3] = 32'd7;
        words[9] = 32'd7;
        target = 32'h0000_0008;
        run(1'b0, 16, 0, "t3");

        for (int k = 0; k < 16; k++) words[k] = 32'h1234_5678;
        target = 32'h1234_5678;
        run(1'b0, 16, 0, "t4");

        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_reset("t5_midreset");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) words[k] = $urandom;
        target = words[$urandom_range(0, 15)];
        run(1'b0, 16, 5, "t5");

        words[0] = 32'd0;
        target = 32'd5;
        run(1'b1, 1, 0, "t6");

        for (int r = 0; r < 4; r++) begin
            hash_addr = 16'($urandom_range(0, 30000));
            result_addr = hash_addr + 16'd1000;
            for (int k = 0; k < 16; k++) words[k] = $urandom >> $urandom_range(0, 31);
            if (r[0]) target = words[$urandom_range(0, 15)];
            else target = $urandom >> $urandom_range(0, 31);
            run(1'b0, 16, 0, $sformatf("rnd%0d", r));
            words[0] = $urandom;
            run(1'b1, 1, 0, $sformatf("rnd1w%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
